// File: rtl/theta_slice_stream_if.sv
// Chunk stream bundle for the sliced Keccak theta step:
// input chunk channel plus output chunk channel with last flag.
interface theta_slice_stream_if #(
  parameter int DATA_W = 200
);
  logic              in_valid;
  logic              in_ready;
  logic [0:DATA_W-1] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [0:DATA_W-1] out_data;
  logic              out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/theta_slice_stream.sv
// Streaming Keccak theta over z-slice chunks; carries the
// cross-chunk column parity (including the z wrap) internally.
module theta_slice_stream #(
  parameter int SLICES = 8,
  parameter int LANE_W = 64,
  parameter int DATA_W = 25 * SLICES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_theta_en,
  output logic                  o_busy,
  theta_slice_stream_if.slave   bus
);
  localparam int NCHUNK = LANE_W / SLICES;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CW-1:0]     r_cnt;
  logic              r_theta;
  logic              r_busy;
  logic [4:0]        r_carry;
  logic              r_ovalid;
  logic              r_olast;
  logic [0:DATA_W-1] r_odata;

  logic              w_in_ready;
  logic              w_start;
  logic              w_acc;
  logic              w_run_acc;
  logic [4:0]        w_par0;
  logic [SLICES-1:0] w_col [5];
  logic [0:DATA_W-1] w_theta;

  // Column parity per x for every slice j of the incoming chunk
  always_comb begin
    for (int x = 0; x < 5; x++) begin
      w_col[x] = '0;
      for (int j = 0; j < SLICES; j++) begin
        for (int y = 0; y < 5; y++) begin
          w_col[x][j] = w_col[x][j]
            ^ bus.in_data[y*5*SLICES + x*SLICES + j];
        end
      end
      w_par0[x] = w_col[x][0];
    end
  end

  // j = SLICES-1 is the lowest z of the chunk; its z-1 neighbour
  // lives in the previous chunk and comes from the carry.
  always_comb begin
    w_theta = '0;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        for (int j = 0; j < SLICES; j++) begin
          w_theta[y*5*SLICES + x*SLICES + j] =
            bus.in_data[y*5*SLICES + x*SLICES + j]
            ^ w_col[(x+4)%5][j]
            ^ ((j == SLICES-1) ? r_carry[(x+1)%5]
                               : w_col[(x+1)%5][(j+1)%SLICES]);
        end
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_start    = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_start = i_start & ~r_busy;
        if (w_start) w_next = PRIME;
      end
      PRIME: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next = RUN;
      end
      RUN: begin
        w_in_ready = ~r_ovalid | bus.out_ready;
        if (bus.in_valid & w_in_ready & (r_cnt == LAST))
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_acc     = bus.in_valid & w_in_ready;
  assign w_run_acc = w_acc & (r_state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_theta  <= 1'b0;
      r_busy   <= 1'b0;
      r_carry  <= '0;
      r_ovalid <= 1'b0;
      r_olast  <= 1'b0;
      r_odata  <= '0;
    end else begin
      if (w_start) begin
        r_theta <= i_theta_en;
        r_cnt   <= '0;
        r_busy  <= 1'b1;
      end else if (r_ovalid & bus.out_ready & r_olast) begin
        r_busy <= 1'b0;
      end
      if (w_acc) r_carry <= w_par0;
      if (w_run_acc) begin
        r_cnt    <= r_cnt + 1'b1;
        r_ovalid <= 1'b1;
        r_odata  <= r_theta ? w_theta : bus.in_data;
        r_olast  <= (r_cnt == LAST);
      end else if (bus.out_ready) begin
        r_ovalid <= 1'b0;
        r_olast  <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_ovalid;
  assign bus.out_data  = r_odata;
  assign bus.out_last  = r_olast;
  assign o_busy        = r_busy;
endmodule

// File: tb/tb_theta_slice_stream.sv
// Bench for theta_slice_stream: full-state theta model, random
// stimulus and backpressure, literal pins for hand-derived cases.
module tb_theta_slice_stream;
  localparam int S  = 8;
  localparam int LW = 64;
  localparam int N  = LW / S;
  localparam int DW = 25 * S;

  typedef logic [0:DW-1] chunk_t;

  logic clk = 0;
  logic rst = 1;
  logic start = 0;
  logic theta_en = 0;
  logic busy;
  bit   bp = 0;

  theta_slice_stream_if #(.DATA_W(DW)) bus ();

  theta_slice_stream #(.SLICES(S), .LANE_W(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (start),
    .i_theta_en (theta_en),
    .o_busy     (busy),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  bit A [5][5][LW];
  bit E [5][5][LW];
  chunk_t exp_q[$];
  bit     exp_last_q[$];
  chunk_t cap_q[$];

  task automatic chk(string name, chunk_t act, chunk_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic chk1(string name, logic act, logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%b exp=%b", name, act, exp);
    end
  endtask

  // Theta over the whole 5x5xLW state, straight from the definition
  task automatic model(input bit te);
    bit C [5][LW];
    for (int x = 0; x < 5; x++)
      for (int z = 0; z < LW; z++) begin
        C[x][z] = 0;
        for (int y = 0; y < 5; y++) C[x][z] ^= A[x][y][z];
      end
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        for (int z = 0; z < LW; z++)
          E[x][y][z] = A[x][y][z] ^ (te &
            (C[(x+4)%5][z] ^ C[(x+1)%5][(z+LW-1)%LW]));
  endtask

  function automatic chunk_t packs(input int k, input bit use_e);
    chunk_t r = '0;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        for (int j = 0; j < S; j++)
          r[y*5*S + x*S + j] = use_e ? E[x][y][k*S+S-1-j]
                                     : A[x][y][k*S+S-1-j];
    return r;
  endfunction

  function automatic chunk_t lit(input int idx[$]);
    chunk_t r = '0;
    foreach (idx[i]) r[idx[i]] = 1'b1;
    return r;
  endfunction

  task automatic clear_a();
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        for (int z = 0; z < LW; z++) A[x][y][z] = 0;
  endtask

  task automatic rand_a();
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        for (int z = 0; z < LW; z++) A[x][y][z] = bit'($urandom_range(0, 1));
  endtask

  task automatic do_start(input bit te);
    @(posedge clk); #1;
    start = 1; theta_en = te;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic send(input chunk_t d);
    int t = 0;
    bus.in_valid = 1; bus.in_data = d;
    @(negedge clk);
    while (!bus.in_ready && t < 1000) begin @(negedge clk); t++; end
    if (!bus.in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout in_ready=%b", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy && t < 2000) begin @(negedge clk); t++; end
    chk1("busy_timeout", busy, 1'b0);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_chunks act=%0d exp=0", exp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic push_exp(input bit te);
    model(te);
    for (int k = 0; k < N; k++) begin
      exp_q.push_back(packs(k, 1));
      exp_last_q.push_back(k == N-1);
    end
  endtask

  task automatic run_pass(input bit te, input int mid_k);
    push_exp(te);
    cap_q.delete();
    do_start(te);
    send(packs(N-1, 0));
    for (int k = 0; k < N; k++) begin
      send(packs(k, 0));
      if (k == mid_k) begin
        start = 1; theta_en = ~te;
        @(posedge clk); #1;
        start = 0; theta_en = te;
        chk1("busy_mid_start", busy, 1'b1);
      end
    end
    wait_idle();
  endtask

  initial begin
    bus.out_ready = 1;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = bp ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end
  end

  // Single compare process: handshakes vs model, stall stability, busy fall
  initial begin
    bit     stall = 0;
    bit     bchk = 0;
    chunk_t pd = '0;
    logic   pl = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 0; bchk = 0;
      end else begin
        if (bchk) begin
          chk1("busy_fall", busy, 1'b0);
          bchk = 0;
        end
        if (stall) begin
          chk1("stall_valid", bus.out_valid, 1'b1);
          chk("stall_data", bus.out_data, pd);
          chk1("stall_last", bus.out_last, pl);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL extra_chunk act=%h exp=none", bus.out_data);
          end else begin
            chk("out_data", bus.out_data, exp_q.pop_front());
            chk1("out_last", bus.out_last, exp_last_q.pop_front());
          end
          cap_q.push_back(bus.out_data);
          if (bus.out_last) bchk = 1;
        end
        stall = bus.out_valid && !bus.out_ready;
        pd = bus.out_data;
        pl = bus.out_last;
      end
    end
  end

  initial begin
    chunk_t l;
    bus.in_valid = 0;
    bus.in_data  = '0;
    repeat (2) @(negedge clk);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_in_ready", bus.in_ready, 1'b0);
    chk1("rst_out_last", bus.out_last, 1'b0);
    chk("rst_out_data", bus.out_data, '0);
    @(posedge clk); #1; rst = 0;

    clear_a();
    run_pass(1, -1);
    n_tests++;
    if (cap_q.size() != N) begin
      n_fail++;
      $display("FAIL zero_count act=%0d exp=%0d", cap_q.size(), N);
    end
    foreach (cap_q[i]) chk("zero_chunk", cap_q[i], '0);

    clear_a();
    A[0][0][0] = 1;
    model(1);
    l = lit('{7, 15, 55, 95, 135, 175, 38, 78, 118, 158, 198});
    chk("model_single", packs(0, 1), l);
    run_pass(1, -1);
    if (cap_q.size() == N) begin
      chk("single_c0", cap_q[0], l);
      for (int k = 1; k < N; k++) chk("single_rest", cap_q[k], '0);
    end else begin
      n_tests++; n_fail++;
      $display("FAIL single_count act=%0d exp=%0d", cap_q.size(), N);
    end

    clear_a();
    A[1][0][63] = 1;
    model(1);
    chk("model_wrap7", packs(7, 1), lit('{8, 16, 56, 96, 136, 176}));
    chk("model_wrap0", packs(0, 1), lit('{7, 47, 87, 127, 167}));
    run_pass(1, -1);
    if (cap_q.size() == N) begin
      chk("wrap_c7", cap_q[7], lit('{8, 16, 56, 96, 136, 176}));
      chk("wrap_c0", cap_q[0], lit('{7, 47, 87, 127, 167}));
      for (int k = 1; k < 7; k++) chk("wrap_rest", cap_q[k], '0);
    end else begin
      n_tests++; n_fail++;
      $display("FAIL wrap_count act=%0d exp=%0d", cap_q.size(), N);
    end

    bp = 1;
    clear_a();
    A[0][0][0] = 1;
    run_pass(1, -1);
    if (cap_q.size() == N)
      chk("bp_single_c0", cap_q[0], l);

    rand_a();
    run_pass(0, 2);
    rand_a();
    run_pass(1, 4);

    bp = 0;
    rand_a();
    push_exp(1);
    do_start(1);
    send(packs(N-1, 0));
    for (int k = 0; k < 4; k++) send(packs(k, 0));
    rst = 1;
    #1;
    chk1("midrst_out_valid", bus.out_valid, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_in_ready", bus.in_ready, 1'b0);
    exp_q.delete();
    exp_last_q.delete();
    @(posedge clk); #1; rst = 0;
    run_pass(1, -1);

    bp = 1;
    for (int p = 0; p < 3; p++) begin
      rand_a();
      run_pass(bit'($urandom_range(0, 1)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/theta_slice_stream.md
Name: theta_slice_stream

Overview:
- Parametrised, streaming successor to the combinational slice theta step of the Keccak datapath used by the Frodo SHAKE core.
- Takes a 1600-bit Keccak state as LANE_W/SLICES chunks of SLICES z-slices, one chunk per beat, and emits theta-applied chunks.
- Internally carries the cross-chunk column parity, including the z=63 to z=0 wrap-around, so the upstream does not supply it.
- Adds valid/ready handshakes, per-permutation sequencing and a theta bypass mode.

Parameters:
- SLICES, 8, z-slices per chunk; must divide LANE_W and be at least 2.
- LANE_W, 64, Keccak lane width; NCHUNK = LANE_W/SLICES chunks per state.
- DATA_W, 25*SLICES, chunk width (derived; do not override).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse that begins a state pass; honoured only when busy=0
- theta_en  in  1  sampled with start; 1 = apply theta, 0 = bypass (out = in)
- in_valid  in  1  input chunk valid
- in_ready  out  1  input chunk accepted when in_valid & in_ready
- in_data  in  DATA_W  chunk, MSB-first [0:DATA_W-1]; see layout below
- out_valid  out  1  output chunk valid
- out_ready  in  1  downstream accept
- out_data  out  DATA_W  theta result, same layout as in_data
- out_last  out  1  high with the final chunk (index NCHUNK-1) of a pass
- busy  out  1  high from accepted start until the final output handshake

Behaviour:
- Layout: bit index = y*5*SLICES + x*SLICES + j. Bit j of a lane in chunk k is z = k*SLICES + (SLICES-1-j).
- Column parity: C[x][z] = XOR over y of A[x][y][z].
- Theta: out[x][y][z] = A[x][y][z] ^ C[x-1][z] ^ C[x+1][z-1]. x is taken mod 5 and z mod LANE_W.
- For j = SLICES-1, C[x+1][z-1] comes from the carry register. The carry holds, per x, the parity at bit j=0 of the previously accepted chunk.
- FSM states are IDLE, PRIME and RUN.
- IDLE:
  - in_ready=0.
  - start with busy=0: latch theta_en, clear the chunk counter, set busy, go to PRIME.
  - start while busy=1 is ignored.
- PRIME:
  - in_ready=1. The upstream sends chunk NCHUNK-1 first.
  - On accept: the carry loads that chunk's j=0 column parity. No output is produced. Go to RUN.
- RUN:
  - Chunks 0..NCHUNK-1 arrive in order.
  - in_ready = !out_valid | out_ready (single-entry output register; full throughput when not stalled).
  - On accept: out_data is registered with 1-cycle latency. out_valid=1, out_last=(counter==NCHUNK-1). The carry updates from this chunk, and the counter increments.
  - Carry update and output use the carry value from before the update.
- After chunk NCHUNK-1 is accepted, go to IDLE. busy stays 1 until that chunk's output handshake.
- out_valid/out_data/out_last hold stable while out_valid & !out_ready.
- Simultaneous out_ready and new input accept in the same cycle: the register is overwritten with the new chunk, with no bubble.
- Bypass: the PRIME beat is still consumed, and out_data = in_data.
- Reset (asynchronous, any time including mid-pass):
  - state=IDLE; out_valid=0, out_last=0, out_data=0, busy=0, in_ready=0.
  - Carry, counter and latched theta_en are cleared.
  - A partial pass is abandoned and restarts only with a new start.

Test Plan:
- All-zero state, theta_en=1, SLICES=8 -> 8 output chunks all zero. out_last only on the 8th, busy falls after the 8th handshake.
- Single bit: chunk0 in_data[7]=1 (x=0,y=0,z=0), all else 0, PRIME chunk zero -> chunk0 output has bits 7, 15,55,95,135,175 and 38,78,118,158,198 set (11 bits). Chunks 1..7 are zero.
- Wrap: chunk7 in_data[8]=1 (x=1,y=0,z=63), sent as the PRIME beat and again as chunk 7 -> chunk7 output has bits 8 and 16,56,96,136,176. Chunk0 output has bits 7,47,87,127,167. All other chunks are zero.
- Backpressure: random out_ready, 30% low, with the single-bit stimulus -> identical data sequence, no dropped or duplicated chunk. Outputs are stable while stalled.
- Bypass and start rules: theta_en=0 with random data -> out equals in per chunk. A start pulse mid-pass is ignored and the stream is unaffected.
- Reset: assert rst after chunk 3 -> out_valid=0 and busy=0 immediately. A new start then a full pass gives results matching the reference model.
